// File: rtl/dbg_loader_if.sv
// dbg_loader_if
//   Groups the signals of the debug controller: the host byte stream
//   (rx_*/tx_*), the CPU debug port (debug, clk_ld, addr, din, we_im, we_dm)
//   and the CPU read-back sources (dout_im, dout_dm, dout_rf, pc_chk).
//   master : the debug controller side (drives rx_ready, tx_*, debug port, busy)
//   slave  : the host/CPU side (drives rx_data/rx_valid, tx_ready, read data)
interface dbg_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        debug;
  logic        clk_ld;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we_im;
  logic        we_dm;
  logic [31:0] dout_im;
  logic [31:0] dout_dm;
  logic [31:0] dout_rf;
  logic [31:0] pc_chk;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf, pc_chk,
    output rx_ready, tx_data, tx_valid, debug, clk_ld, addr, din,
           we_im, we_dm, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf, pc_chk,
    input  rx_ready, tx_data, tx_valid, debug, clk_ld, addr, din,
           we_im, we_dm, busy
  );
endinterface

// File: rtl/dbg_loader.sv
// dbg_loader
//   Host-side debug controller. Decodes framed byte commands from the host
//   (W write word, R read word, P read PC, H halt, G go, S single step),
//   drives the CPU debug port and answers with ACK 0x06, NAK 0x15 or four
//   big-endian data bytes.
// Ports
//   clk    : system clock
//   rstn   : asynchronous active-low reset
//   bus    : dbg_loader_if.master (byte stream, debug port, read-back data)
// Parameters
//   ADDR_W : bits of the 16-bit frame address kept on addr (zero-extended)
module dbg_loader #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  dbg_loader_if.master bus
);

  localparam logic [7:0] OPC_W = 8'h57;
  localparam logic [7:0] OPC_R = 8'h52;
  localparam logic [7:0] OPC_P = 8'h50;
  localparam logic [7:0] OPC_H = 8'h48;
  localparam logic [7:0] OPC_G = 8'h47;
  localparam logic [7:0] OPC_S = 8'h53;
  localparam logic [7:0] C_ACK = 8'h06;
  localparam logic [7:0] C_NAK = 8'h15;

  localparam logic [31:0] C_AMASK =
    (ADDR_W >= 32) ? '1 : ((32'd1 << ADDR_W) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_TGT, S_ADR, S_DAT, S_EXEC, S_WAIT, S_SEND, S_ACK
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE, OP_WR, OP_RD, OP_PC
  } op_e;

  state_e      r_state, w_nxt_state;
  op_e         r_op, w_nxt_op;
  logic [1:0]  r_tgt, w_nxt_tgt;
  logic [2:0]  r_cnt, w_nxt_cnt;
  logic [7:0]  r_a1, w_nxt_a1;
  logic [23:0] r_dbuf, w_nxt_dbuf;
  logic [31:0] r_addr, w_nxt_addr;
  logic [31:0] r_din, w_nxt_din;
  logic        r_we_im, w_nxt_we_im;
  logic        r_we_dm, w_nxt_we_dm;
  logic        r_clk_ld, w_nxt_clk_ld;
  logic        r_debug, w_nxt_debug;
  logic [23:0] r_shift, w_nxt_shift;
  logic [7:0]  r_tx_data, w_nxt_tx_data;
  logic        r_tx_valid, w_nxt_tx_valid;
  logic        r_rx_ready, w_nxt_rx_ready;

  logic        w_rx_fire;
  logic        w_tx_fire;
  logic [31:0] w_rd_word;

  assign w_rx_fire = bus.rx_valid & r_rx_ready;
  assign w_tx_fire = r_tx_valid & bus.tx_ready;

  // Read-back source: PC for 'P', otherwise the target selected in the frame.
  always_comb begin
    w_rd_word = bus.dout_rf;
    if (r_op == OP_PC) begin
      w_rd_word = bus.pc_chk;
    end else begin
      case (r_tgt)
        2'd0:    w_rd_word = bus.dout_im;
        2'd1:    w_rd_word = bus.dout_dm;
        default: w_rd_word = bus.dout_rf;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NONE;
      r_tgt      <= '0;
      r_cnt      <= '0;
      r_a1       <= '0;
      r_dbuf     <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_we_im    <= 1'b0;
      r_we_dm    <= 1'b0;
      r_clk_ld   <= 1'b0;
      r_debug    <= 1'b1;
      r_shift    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_rx_ready <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_op       <= w_nxt_op;
      r_tgt      <= w_nxt_tgt;
      r_cnt      <= w_nxt_cnt;
      r_a1       <= w_nxt_a1;
      r_dbuf     <= w_nxt_dbuf;
      r_addr     <= w_nxt_addr;
      r_din      <= w_nxt_din;
      r_we_im    <= w_nxt_we_im;
      r_we_dm    <= w_nxt_we_dm;
      r_clk_ld   <= w_nxt_clk_ld;
      r_debug    <= w_nxt_debug;
      r_shift    <= w_nxt_shift;
      r_tx_data  <= w_nxt_tx_data;
      r_tx_valid <= w_nxt_tx_valid;
      r_rx_ready <= w_nxt_rx_ready;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_op       = r_op;
    w_nxt_tgt      = r_tgt;
    w_nxt_cnt      = r_cnt;
    w_nxt_a1       = r_a1;
    w_nxt_dbuf     = r_dbuf;
    w_nxt_addr     = r_addr;
    w_nxt_din      = r_din;
    w_nxt_we_im    = 1'b0;
    w_nxt_we_dm    = 1'b0;
    w_nxt_clk_ld   = 1'b0;
    w_nxt_debug    = r_debug;
    w_nxt_shift    = r_shift;
    w_nxt_tx_data  = r_tx_data;
    w_nxt_tx_valid = r_tx_valid;

    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          // Single-byte replies are loaded on the accepting edge.
          w_nxt_state    = S_ACK;
          w_nxt_tx_valid = 1'b1;
          w_nxt_tx_data  = C_NAK;
          case (bus.rx_data)
            OPC_W: begin
              if (r_debug) begin
                w_nxt_op       = OP_WR;
                w_nxt_state    = S_TGT;
                w_nxt_tx_valid = 1'b0;
              end
            end
            OPC_R: begin
              w_nxt_op       = OP_RD;
              w_nxt_state    = S_TGT;
              w_nxt_tx_valid = 1'b0;
            end
            OPC_P: begin
              w_nxt_op       = OP_PC;
              w_nxt_state    = S_WAIT;
              w_nxt_tx_valid = 1'b0;
            end
            OPC_H: begin
              w_nxt_debug   = 1'b1;
              w_nxt_tx_data = C_ACK;
            end
            OPC_G: begin
              w_nxt_debug   = 1'b0;
              w_nxt_tx_data = C_ACK;
            end
            OPC_S: begin
              if (r_debug) begin
                w_nxt_clk_ld   = 1'b1;
                w_nxt_state    = S_EXEC;
                w_nxt_tx_valid = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end

      S_TGT: begin
        if (w_rx_fire) begin
          // RF is readable but not writable.
          if ((r_op == OP_WR) ? (bus.rx_data > 8'd1) : (bus.rx_data > 8'd2)) begin
            w_nxt_state    = S_ACK;
            w_nxt_tx_valid = 1'b1;
            w_nxt_tx_data  = C_NAK;
          end else begin
            w_nxt_tgt   = bus.rx_data[1:0];
            w_nxt_cnt   = '0;
            w_nxt_state = S_ADR;
          end
        end
      end

      S_ADR: begin
        if (w_rx_fire) begin
          if (r_cnt == 3'd0) begin
            w_nxt_a1  = bus.rx_data;
            w_nxt_cnt = 3'd1;
          end else begin
            w_nxt_addr  = {16'h0000, r_a1, bus.rx_data} & C_AMASK;
            w_nxt_cnt   = '0;
            w_nxt_state = (r_op == OP_WR) ? S_DAT : S_WAIT;
          end
        end
      end

      S_DAT: begin
        if (w_rx_fire) begin
          if (r_cnt == 3'd3) begin
            w_nxt_din   = {r_dbuf, bus.rx_data};
            w_nxt_we_im = (r_tgt == 2'd0);
            w_nxt_we_dm = (r_tgt == 2'd1);
            w_nxt_state = S_EXEC;
          end else begin
            w_nxt_dbuf = {r_dbuf[15:0], bus.rx_data};
            w_nxt_cnt  = r_cnt + 3'd1;
          end
        end
      end

      S_EXEC: begin
        w_nxt_state    = S_ACK;
        w_nxt_tx_valid = 1'b1;
        w_nxt_tx_data  = C_ACK;
      end

      S_WAIT: begin
        w_nxt_tx_data  = w_rd_word[31:24];
        w_nxt_shift    = w_rd_word[23:0];
        w_nxt_tx_valid = 1'b1;
        w_nxt_cnt      = '0;
        w_nxt_state    = S_SEND;
      end

      S_SEND: begin
        if (w_tx_fire) begin
          if (r_cnt == 3'd3) begin
            w_nxt_tx_valid = 1'b0;
            w_nxt_state    = S_IDLE;
          end else begin
            w_nxt_tx_data = r_shift[23:16];
            w_nxt_shift   = {r_shift[15:0], 8'h00};
            w_nxt_cnt     = r_cnt + 3'd1;
          end
        end
      end

      S_ACK: begin
        if (w_tx_fire) begin
          w_nxt_tx_valid = 1'b0;
          w_nxt_state    = S_IDLE;
        end
      end

      default: w_nxt_state = S_IDLE;
    endcase

    w_nxt_rx_ready = (w_nxt_state == S_IDLE) || (w_nxt_state == S_TGT) ||
                     (w_nxt_state == S_ADR)  || (w_nxt_state == S_DAT);
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.debug    = r_debug;
  assign bus.clk_ld   = r_clk_ld;
  assign bus.addr     = r_addr;
  assign bus.din      = r_din;
  assign bus.we_im    = r_we_im;
  assign bus.we_dm    = r_we_dm;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_dbg_loader.sv
// tb_dbg_loader
//   Drives command frames into dbg_loader, models the CPU memories as
//   responders, and checks replies, write strobes, steps and debug state
//   against a frame-level model.
module tb_dbg_loader;

  logic clk;
  logic rstn;

  dbg_loader_if bus ();

  dbg_loader #(.ADDR_W(16)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU-side responders
  logic [31:0] im_mem [256];
  logic [31:0] dm_mem [256];
  logic [31:0] rf_mem [32];
  logic [31:0] pc_val;

  always @(posedge clk) begin
    if (bus.we_im) im_mem[bus.addr[7:0]] <= bus.din;
    if (bus.we_dm) dm_mem[bus.addr[7:0]] <= bus.din;
  end

  assign bus.dout_im = im_mem[bus.addr[7:0]];
  assign bus.dout_dm = dm_mem[bus.addr[7:0]];
  assign bus.dout_rf = rf_mem[bus.addr[4:0]];
  assign bus.pc_chk  = pc_val;

  // Frame-level model
  logic [7:0]  frm [$];
  logic [7:0]  m_txq [$];
  logic [7:0]  rx_log [$];
  logic [1:0]  exp_wt [$];
  logic [31:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [31:0] m_im [256];
  logic [31:0] m_dm [256];
  int          m_steps;
  logic        m_debug;

  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, outputs against the model.
  bit         prev_stall;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      chk("debug", {31'b0, bus.debug}, {31'b0, m_debug});
      chk("we_both", {30'b0, bus.we_im, bus.we_dm} & 32'h3, (bus.we_im & bus.we_dm) ? 32'h0 : ({30'b0, bus.we_im, bus.we_dm}));
      if (bus.we_im | bus.we_dm) begin
        if (exp_wa.size() == 0) begin
          chk("we_unexpected", {30'b0, bus.we_im, bus.we_dm}, 32'h0);
        end else begin
          logic [1:0]  t;
          logic [31:0] a, d;
          t = exp_wt.pop_front();
          a = exp_wa.pop_front();
          d = exp_wd.pop_front();
          chk("we_im", {31'b0, bus.we_im}, {31'b0, (t == 2'd0)});
          chk("we_dm", {31'b0, bus.we_dm}, {31'b0, (t == 2'd1)});
          chk("wr_addr", bus.addr, a);
          chk("wr_din", bus.din, d);
        end
      end
      if (bus.clk_ld) begin
        chk("clk_ld_expected", {31'b0, bus.clk_ld}, (m_steps > 0) ? 32'h1 : 32'h0);
        if (m_steps > 0) m_steps--;
      end
      if (prev_stall) begin
        chk("tx_hold_valid", {31'b0, bus.tx_valid}, 32'h1);
        chk("tx_hold_data", {24'b0, bus.tx_data}, {24'b0, prev_data});
      end
      if (bus.tx_valid && bus.tx_ready) begin
        rx_log.push_back(bus.tx_data);
        if (m_txq.size() == 0) chk("tx_extra", {31'b0, bus.tx_valid}, 32'h0);
        else chk("tx_byte", {24'b0, bus.tx_data}, {24'b0, m_txq.pop_front()});
      end
      prev_stall = bus.tx_valid & !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("rx_accept", {31'b0, bus.rx_ready}, 32'h1);
      bus.rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    m_txq.push_back(w[31:24]);
    m_txq.push_back(w[23:16]);
    m_txq.push_back(w[15:8]);
    m_txq.push_back(w[7:0]);
  endtask

  // Sends frm[] through the DUT. The model decides how many bytes the DUT
  // consumes and what it must answer.
  task automatic do_frame(input bit stall);
    int          n;
    bit          lat;
    bit          ok;
    logic        nd;
    logic [7:0]  op, t;
    logic [31:0] a, d, w;
    op  = frm[0];
    n   = 1;
    lat = 1'b0;
    nd  = m_debug;
    rx_log.delete();
    case (op)
      8'h57: begin
        if (!m_debug) m_txq.push_back(8'h15);
        else begin
          t = frm[1];
          if (t > 8'd1) begin
            n = 2;
            m_txq.push_back(8'h15);
          end else begin
            n = 8;
            a = {16'h0, frm[2], frm[3]};
            d = {frm[4], frm[5], frm[6], frm[7]};
            exp_wt.push_back(t[1:0]);
            exp_wa.push_back(a);
            exp_wd.push_back(d);
            if (t == 8'd0) m_im[a[7:0]] = d; else m_dm[a[7:0]] = d;
            m_txq.push_back(8'h06);
            lat = 1'b1;
          end
        end
      end
      8'h52: begin
        t = frm[1];
        if (t > 8'd2) begin
          n = 2;
          m_txq.push_back(8'h15);
        end else begin
          n = 4;
          a = {16'h0, frm[2], frm[3]};
          w = (t == 8'd0) ? m_im[a[7:0]] : (t == 8'd1) ? m_dm[a[7:0]] : rf_mem[a[4:0]];
          push_word(w);
          lat = 1'b1;
        end
      end
      8'h50: begin
        push_word(pc_val);
        lat = 1'b1;
      end
      8'h48: begin nd = 1'b1; m_txq.push_back(8'h06); end
      8'h47: begin nd = 1'b0; m_txq.push_back(8'h06); end
      8'h53: begin
        if (m_debug) begin
          m_steps++;
          m_txq.push_back(8'h06);
          lat = 1'b1;
        end else m_txq.push_back(8'h15);
      end
      default: m_txq.push_back(8'h15);
    endcase

    for (int i = 0; i < n; i++) begin
      send_byte(frm[i], ok);
      if (!ok) return;
    end
    m_debug = nd;

    if (lat) begin
      chk("lat_tx_idle", {31'b0, bus.tx_valid}, 32'h0);
      if (op == 8'h57) chk("lat_we", {31'b0, bus.we_im | bus.we_dm}, 32'h1);
      if (op == 8'h53) chk("lat_clk_ld", {31'b0, bus.clk_ld}, 32'h1);
      @(posedge clk);
      #1;
      chk("lat_tx_valid", {31'b0, bus.tx_valid}, 32'h1);
    end
    if (stall) begin
      bus.tx_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      bus.tx_ready = 1'b1;
    end
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (m_txq.size() == 0 && !bus.busy) break;
    end
    chk("reply_done", m_txq.size(), 32'h0);
    chk("idle_busy", {31'b0, bus.busy}, 32'h0);
    chk("idle_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
    chk("wr_pending", exp_wa.size(), 32'h0);
    chk("step_pending", m_steps, 32'h0);
  endtask

  task automatic chk_word(input string nm, input logic [31:0] e);
    chk({nm, "_len"}, rx_log.size(), 32'd4);
    chk(nm, {rx_log[0], rx_log[1], rx_log[2], rx_log[3]}, e);
  endtask

  task automatic chk_one(input string nm, input logic [7:0] e);
    chk({nm, "_len"}, rx_log.size(), 32'd1);
    chk(nm, {24'b0, rx_log[0]}, {24'b0, e});
  endtask

  task automatic chk_reset_values();
    chk("rst_debug", {31'b0, bus.debug}, 32'h1);
    chk("rst_clk_ld", {31'b0, bus.clk_ld}, 32'h0);
    chk("rst_we", {30'b0, bus.we_im, bus.we_dm}, 32'h0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_din", bus.din, 32'h0);
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
    chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    n_chk    = 0;
    n_fail   = 0;
    m_steps  = 0;
    m_debug  = 1'b1;
    pc_val   = 32'h0000_3000;
    for (int unsigned i = 0; i < 256; i++) begin
      m_im[i] = '0;
      m_dm[i] = '0;
    end
    for (int unsigned i = 0; i < 32; i++) rf_mem[i] = 32'h0101_0101 * i;
    rf_mem[3]    = 32'h1234_5678;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    rstn         = 1'b1;
    #2 rstn = 1'b0;
    #1 chk_reset_values();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1 chk("rel_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
    chk("rel_tx_valid", {31'b0, bus.tx_valid}, 32'h0);

    frm = '{8'h50};
    do_frame(1'b0);
    chk_word("P_pc", 32'h0000_3000);

    frm = '{8'h57, 8'h00, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_frame(1'b0);
    chk_one("W_im_ack", 8'h06);
    chk("W_addr", bus.addr, 32'd5);
    chk("W_din", bus.din, 32'hDEAD_BEEF);

    frm = '{8'h52, 8'h00, 8'h00, 8'h05};
    do_frame(1'b0);
    chk_word("R_im5", 32'hDEAD_BEEF);

    frm = '{8'h57, 8'h01, 8'h00, 8'h03, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    do_frame(1'b0);
    chk_one("W_dm_ack", 8'h06);
    frm = '{8'h52, 8'h01, 8'h00, 8'h03};
    do_frame(1'b0);
    chk_word("R_dm3", 32'hCAFE_F00D);
    frm = '{8'h52, 8'h02, 8'h00, 8'h03};
    do_frame(1'b0);
    chk_word("R_rf3", 32'h1234_5678);

    frm = '{8'h48};
    do_frame(1'b0);
    chk_one("H_repeat", 8'h06);
    frm = '{8'h53};
    do_frame(1'b0);
    chk_one("S_halted", 8'h06);

    frm = '{8'h57, 8'h02};
    do_frame(1'b0);
    chk_one("W_rf_nak", 8'h15);
    frm = '{8'h52, 8'h03};
    do_frame(1'b0);
    chk_one("R_t3_nak", 8'h15);
    frm = '{8'h00};
    do_frame(1'b0);
    chk_one("bad_op_nak", 8'h15);

    frm = '{8'h52, 8'h00, 8'h00, 8'h05};
    do_frame(1'b1);
    chk_word("R_stall", 32'hDEAD_BEEF);

    frm = '{8'h47};
    do_frame(1'b0);
    chk_one("G_ack", 8'h06);
    chk("G_debug", {31'b0, bus.debug}, 32'h0);
    frm = '{8'h57};
    do_frame(1'b0);
    chk_one("W_running_nak", 8'h15);
    frm = '{8'h53};
    do_frame(1'b0);
    chk_one("S_running_nak", 8'h15);
    frm = '{8'h47};
    do_frame(1'b0);
    chk_one("G_repeat", 8'h06);
    frm = '{8'h52, 8'h01, 8'h00, 8'h03};
    do_frame(1'b0);
    chk_word("R_running", 32'hCAFE_F00D);
    frm = '{8'h48};
    do_frame(1'b0);
    chk_one("H_ack", 8'h06);

    // Reset in the middle of a write frame
    send_byte(8'h57, ok);
    send_byte(8'h00, ok);
    send_byte(8'h00, ok);
    rstn = 1'b0;
    m_debug = 1'b1;
    #1 chk_reset_values();
    m_txq.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1 chk("rel2_rx_ready", {31'b0, bus.rx_ready}, 32'h1);
    frm = '{8'h48};
    do_frame(1'b0);
    chk_one("H_after_rst", 8'h06);
    chk("no_wr_after_rst", {30'b0, bus.we_im, bus.we_dm}, 32'h0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
